// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//
// Purpose:
//   Multi-channel edge detector for raw asynchronous level inputs such as
//   buttons and sensor strobes. Each channel is handled on its own:
//     - a SYNC_STAGES-deep synchroniser,
//     - an optional glitch filter,
//     - an edge detector with a run-time mode (none / rise / fall / both),
//     - a registered one-cycle edge pulse,
//     - sticky pending and overrun flags with a per-channel clear.
//   irq is the OR of all pending bits.
//
// Optional feature:
//   MULTI_EDGE_FILTER_EN - when defined, each channel gets a stability counter
//   between the synchroniser and the detector. The filtered level follows the
//   synchronised level only after the two have differed for FILTER_CYCLES
//   consecutive cycles. This adds FILTER_CYCLES cycles of latency. When the
//   macro is undefined, no counter logic exists.
//
// Parameters:
//   NUM_CH        number of channels (1..32)
//   SYNC_STAGES   synchroniser depth (2..4)
//   FILTER_CYCLES glitch filter stability count (2..255). Only used with
//                 MULTI_EDGE_FILTER_EN.
//
// Ports:
//   clk         in   system clock; all logic uses the rising edge
//   rst_n       in   asynchronous active-low reset
//   level       in   [NUM_CH]    raw asynchronous inputs
//   mode        in   [2*NUM_CH]  per-channel mode, bits [2i+1:2i]:
//                                00 none, 01 rise, 10 fall, 11 both (used live)
//   clr         in   [NUM_CH]    clear of pending/overrun; takes effect next edge
//   level_sync  out  [NUM_CH]    synchronised (and filtered) level
//   edge_tick   out  [NUM_CH]    one-cycle pulse per qualified edge
//   pending     out  [NUM_CH]    sticky edge-seen flag
//   overrun     out  [NUM_CH]    sticky edge-while-pending flag
//   irq         out  1           OR of pending
// -----------------------------------------------------------------------------
module multi_edge_detect #(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     level,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]     clr,
  output logic [NUM_CH-1:0]     level_sync,
  output logic [NUM_CH-1:0]     edge_tick,
  output logic [NUM_CH-1:0]     pending,
  output logic [NUM_CH-1:0]     overrun,
  output logic                  irq
);

  // Per-channel datapath signals, gathered into vectors for the outputs.
  logic [NUM_CH-1:0] sync_out;   // last synchroniser stage
  logic [NUM_CH-1:0] det_in;     // detector input (filtered when enabled)
  logic [NUM_CH-1:0] qualified;  // edge accepted by the current mode

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch

      // -----------------------------------------------------------------
      // Synchroniser: bit 0 captures the raw input. The top bit feeds the
      // rest of the channel.
      // -----------------------------------------------------------------
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], level[gi]};
        end
      end

      assign sync_out[gi] = sync_reg[SYNC_STAGES-1];

`ifdef MULTI_EDGE_FILTER_EN
      // -----------------------------------------------------------------
      // Glitch filter. The counter tracks how many consecutive cycles the
      // synchronised value has differed from the filtered level.
      //
      // Because the signal is one bit wide, a change of the synced value
      // while it differs from filt_reg can only bring it back to filt_reg.
      // The "equal" branch therefore also covers the "synced value
      // changed" restart.
      //
      // Once the difference has lasted FILTER_CYCLES cycles, filt_reg takes
      // the new value.
      // -----------------------------------------------------------------
      localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      logic [CNT_W-1:0] cnt_reg;
      logic             filt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (sync_out[gi] == filt_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          filt_reg <= sync_out[gi];
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end

      assign det_in[gi] = filt_reg;
`else
      assign det_in[gi] = sync_out[gi];
`endif

      // -----------------------------------------------------------------
      // Edge detector. level_sync doubles as the "previous" register, so
      // the tick and the level_sync update happen on the same edge.
      //
      // prev resets to 0. An input held high through reset therefore
      // yields a rise tick after release; this is intended behaviour.
      // -----------------------------------------------------------------
      logic ls_reg;
      logic tick_reg;
      logic pend_reg;
      logic ovr_reg;
      logic rise;
      logic fall;

      assign rise = det_in[gi] & ~ls_reg;
      assign fall = ~det_in[gi] & ls_reg;
      assign qualified[gi] = (rise & mode[2*gi]) | (fall & mode[2*gi+1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ls_reg   <= 1'b0;
          tick_reg <= 1'b0;
        end else begin
          ls_reg   <= det_in[gi];
          tick_reg <= qualified[gi];
        end
      end

      // -----------------------------------------------------------------
      // Sticky flags.
      //
      // pending is set by the registered tick, so it rises one cycle after
      // edge_tick. A set in the same cycle as clr wins over the clear.
      //
      // overrun records a tick that lands while pending is already set,
      // unless that same cycle clears the channel.
      // -----------------------------------------------------------------
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_reg <= 1'b0;
          ovr_reg  <= 1'b0;
        end else begin
          pend_reg <= tick_reg | (pend_reg & ~clr[gi]);
          ovr_reg  <= (tick_reg & pend_reg & ~clr[gi]) | (ovr_reg & ~clr[gi]);
        end
      end

      assign level_sync[gi] = ls_reg;
      assign edge_tick[gi]  = tick_reg;
      assign pending[gi]    = pend_reg;
      assign overrun[gi]    = ovr_reg;
    end
  endgenerate

  // irq is combinational, but only from registered pending bits.
  assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detect.sv
// -----------------------------------------------------------------------------
// Self-checking bench for multi_edge_detect (NUM_CH=4, SYNC_STAGES=2,
// FILTER_CYCLES=4).
//
// The reference model keeps a history of sampled input levels. The detector
// view is the sample taken SYNC_STAGES edges ago, and edges are found by
// comparing neighbouring history entries.
// -----------------------------------------------------------------------------
module tb_multi_edge_detect;
  localparam int N = 4;
  localparam int S = 2;
  localparam int F = 4;
`ifdef MULTI_EDGE_FILTER_EN
  localparam int LAT = S + F;
`else
  localparam int LAT = S;
`endif
  // Pulse width for the mode tests: long enough to pass the filter if present.
  localparam int PW = (LAT > S) ? F + 2 : 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   level = '0;
  logic [2*N-1:0] mode = '0;
  logic [N-1:0]   clr = '0;
  logic [N-1:0]   level_sync, edge_tick, pending, overrun;
  logic           irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_edge_detect #(.NUM_CH(N), .SYNC_STAGES(S), .FILTER_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .level(level), .mode(mode), .clr(clr),
    .level_sync(level_sync), .edge_tick(edge_tick), .pending(pending),
    .overrun(overrun), .irq(irq)
  );

  // ---------------- reference model (unfiltered behaviour) ----------------
  logic [N-1:0] hist [0:S+1];   // hist[j] = level sampled j edges ago
  logic [N-1:0] m_sync, m_tick, m_pend, m_ovr;

  task automatic model_reset();
    for (int j = 0; j <= S + 1; j++) hist[j] = '0;
    m_sync = '0; m_tick = '0; m_pend = '0; m_ovr = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] cur, old, q, np, no;
    for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = level;
    cur = hist[S];
    old = hist[S+1];
    q = '0;
    for (int i = 0; i < N; i++) begin
      case (mode[2*i +: 2])
        2'b01:   q[i] = cur[i] & ~old[i];
        2'b10:   q[i] = ~cur[i] & old[i];
        2'b11:   q[i] = cur[i] ^ old[i];
        default: q[i] = 1'b0;
      endcase
    end
    np = m_tick | (m_pend & ~clr);
    no = (m_tick & m_pend & ~clr) | (m_ovr & ~clr);
    m_pend = np; m_ovr = no; m_tick = q; m_sync = cur;
  endtask

  task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
`ifndef MULTI_EDGE_FILTER_EN
    chk("model_sync", level_sync, m_sync);
    chk("model_tick", edge_tick, m_tick);
    chk("model_pend", pending, m_pend);
    chk("model_ovr",  overrun, m_ovr);
    chk("model_irq",  {3'b0, irq}, {3'b0, |m_pend});
`endif
  endtask

  task automatic check_all_zero(string name);
    chk({name, "_sync"}, level_sync, '0);
    chk({name, "_tick"}, edge_tick, '0);
    chk({name, "_pend"}, pending, '0);
    chk({name, "_ovr"},  overrun, '0);
    chk({name, "_irq"},  {3'b0, irq}, '0);
  endtask

  task automatic apply_reset(logic [N-1:0] lv, logic [2*N-1:0] md);
    level = lv; mode = md; clr = '0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  // Drive a pulse of 'width' cycles on one channel and watch 'total' cycles.
  task automatic pulse_run(int ch, int width, int total,
                           output int cnt, output int first);
    cnt = 0; first = -1;
    for (int j = 0; j < total; j++) begin
      level[ch] = (j < width) ? 1'b1 : 1'b0;
      step();
      if (edge_tick[ch]) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
  endtask

  typedef struct {
    logic [3:0] lv, cl, tick, pend, ovr, sync;
  } vec_t;

  vec_t tbl [17];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cnt, first, last;

`ifndef MULTI_EDGE_FILTER_EN
    // ---------- table-driven sequence, all channels in mode 11 ----------
    tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1};
    tbl[3]  = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1};
    tbl[4]  = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[5]  = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[6]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[7]  = '{4'h1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h5};
    tbl[8]  = '{4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h1};
    tbl[9]  = '{4'h1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h1};
    tbl[10] = '{4'h1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[11] = '{4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[12] = '{4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[13] = '{4'h9, 4'h0, 4'h8, 4'h0, 4'h0, 4'h9};
    tbl[14] = '{4'h9, 4'h8, 4'h0, 4'h8, 4'h0, 4'h9};
    tbl[15] = '{4'h9, 4'h0, 4'h0, 4'h8, 4'h0, 4'h9};
    tbl[16] = '{4'h9, 4'h8, 4'h0, 4'h0, 4'h0, 4'h9};

    apply_reset('0, 8'hFF);
    for (int r = 0; r < 17; r++) begin
      level = tbl[r].lv;
      clr   = tbl[r].cl;
      step();
      chk($sformatf("tbl%0d_tick", r), edge_tick, tbl[r].tick);
      chk($sformatf("tbl%0d_pend", r), pending, tbl[r].pend);
      chk($sformatf("tbl%0d_ovr", r),  overrun, tbl[r].ovr);
      chk($sformatf("tbl%0d_sync", r), level_sync, tbl[r].sync);
      chk($sformatf("tbl%0d_irq", r),  {3'b0, irq}, {3'b0, |tbl[r].pend});
    end
    clr = '0;
`endif

    // ---------- ch1 rise-only, then fall-only ----------
    apply_reset('0, 8'b0000_0100);
    pulse_run(1, PW, PW + LAT + 4, cnt, first);
    chk_int("rise_only_count", cnt, 1);
    chk_int("rise_only_at", first, LAT);

    apply_reset('0, 8'b0000_1000);
    pulse_run(1, PW, PW + LAT + 4, cnt, first);
    chk_int("fall_only_count", cnt, 1);
    chk_int("fall_only_at", first, PW + LAT);

    // ---------- mode 00: level_sync tracks, nothing else ----------
    apply_reset('0, 8'h00);
    pulse_run(2, PW, PW + LAT + 4, cnt, first);
    chk_int("mode00_count", cnt, 0);
    level[2] = 1'b1;
    repeat (LAT + 1) step();
    chk("mode00_sync", level_sync, 4'h4);
    chk("mode00_pend", pending, 4'h0);
    level = '0;

`ifndef MULTI_EDGE_FILTER_EN
    // ---------- back-to-back toggles in mode 11 ----------
    apply_reset('0, 8'h03);
    cnt = 0; first = -1; last = -1;
    for (int j = 0; j < 6 + LAT + 3; j++) begin
      if (j < 6) level[0] = ~level[0];
      step();
      if (edge_tick[0]) begin
        cnt++;
        if (first < 0) first = j;
        last = j;
      end
    end
    chk_int("toggle_count", cnt, 6);
    chk_int("toggle_first", first, LAT);
    chk_int("toggle_last", last, LAT + 5);
`endif

    // ---------- level held high through reset, rise mode ----------
    apply_reset(4'hF, 8'h55);
    for (int j = 0; j <= LAT; j++) begin
      step();
      if (j < LAT) chk($sformatf("held_tick_%0d", j), edge_tick, 4'h0);
    end
    chk("held_tick_at_lat", edge_tick, 4'hF);
    // Reset while the tick is high: outputs clear without a clock edge.
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    level = '0;

`ifdef MULTI_EDGE_FILTER_EN
    // ---------- glitch filter ----------
    apply_reset('0, 8'h01);
    pulse_run(0, F - 1, F + LAT + 6, cnt, first);
    chk_int("filt_glitch_count", cnt, 0);
    chk("filt_glitch_sync", level_sync, 4'h0);
    pulse_run(0, F + 2, F + 2 + LAT + 6, cnt, first);
    chk_int("filt_long_count", cnt, 1);
    chk_int("filt_long_at", first, S + F);
`else
    // ---------- randomized run against the model ----------
    apply_reset(4'($urandom), 8'($urandom));
    for (int j = 0; j < 600; j++) begin
      level = 4'($urandom);
      mode  = 8'($urandom);
      clr   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step();
    end
    clr = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
